dbus_sram_responder: RTL and testbench



---
 rtl/dbus_sram_responder_if.sv | 27 ++
 rtl/dbus_sram_responder.sv | 153 +++++++++++++++
 tb/tb_dbus_sram_responder.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/dbus_sram_responder_if.sv
// Data-bus request/response bundles and the interface that carries them
// between the core's MEM stage (master) and a memory responder (slave).
//   dreq  : valid, addr (byte address), size (log2 bytes), strobe (byte
//           enables, nonzero = store), data (store data)
//   dresp : addr_ok (request accepted), data_ok (response valid), data

typedef struct packed {
  logic        valid;
  logic [63:0] addr;
  logic [2:0]  size;
  logic [7:0]  strobe;
  logic [63:0] data;
} dbus_req_t;

typedef struct packed {
  logic        addr_ok;
  logic        data_ok;
  logic [63:0] data;
} dbus_resp_t;

interface dbus_sram_responder_if;
  dbus_req_t  dreq;
  dbus_resp_t dresp;

  modport master (output dreq, input dresp);
  modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: word-addressed 64-bit SRAM model answering dbus
// requests with a programmable latency and per-byte write strobes.
//
// Ports:
//   clk      : clock, all state changes on the rising edge
//   reset_n  : asynchronous active-low reset (storage itself is not reset)
//   dbus     : slave side of dbus_sram_responder_if (dreq in, dresp out)
//   busy     : high while a request is outstanding (WAIT or RESP)
//   err      : one-cycle pulse with data_ok for an out-of-range access
//
// Parameters: DEPTH (words, power of two), LATENCY (>= 1),
//             BASE_ADDR (byte address of word 0).
// Optional feature: define DBUS_SRAM_JITTER_EN to add 0..3 extra wait
// cycles per request, drawn from an 8-bit LFSR (taps 8,6,5,4, seed 8'hA5).

module dbus_sram_responder #(
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 1,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic                  clk,
  input  logic                  reset_n,
  dbus_sram_responder_if.slave  dbus,
  output logic                  busy,
  output logic                  err
);

  localparam int unsigned IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(LATENCY + 4);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t         state;
  logic [CW-1:0]  cnt;
  logic [63:0]    addr_q;
  logic [7:0]     strobe_q;
  logic [63:0]    wdata_q;
  logic           data_ok_q;
  logic [63:0]    rdata_q;
  logic           err_q;

  logic [63:0]    mem [DEPTH];

  logic [63:0]    cur_addr;
  logic [63:0]    off;
  logic [IW-1:0]  idx;
  logic           in_range;
  logic           accept;
  logic [1:0]     jitter;
  logic [CW-1:0]  load_cnt;

  // In IDLE the incoming address is decoded directly so a zero-wait request
  // can capture its read data on the accepting edge; afterwards the latched
  // address drives both the read and the RESP-cycle write.
  assign cur_addr = (state == IDLE) ? dbus.dreq.addr : addr_q;
  assign off      = cur_addr - BASE_ADDR;
  assign idx      = off[IW+2:3];
  assign in_range = (cur_addr >= BASE_ADDR) && ((off >> 3) < 64'(DEPTH));
  assign accept   = (state == IDLE) && dbus.dreq.valid;
  assign load_cnt = CW'(LATENCY - 1) + CW'(jitter);

`ifdef DBUS_SRAM_JITTER_EN
  logic [7:0] lfsr;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      lfsr <= 8'hA5;
    end else if (accept) begin
      lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
    end
  end

  assign jitter = lfsr[1:0];
`else
  assign jitter = 2'b00;
`endif

  // Response outputs are registered on the edge that enters RESP, so the
  // read captures the pre-write word; the write lands on the edge leaving RESP.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      cnt       <= '0;
      addr_q    <= '0;
      strobe_q  <= '0;
      wdata_q   <= '0;
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      data_ok_q <= 1'b0;
      rdata_q   <= '0;
      err_q     <= 1'b0;
      unique case (state)
        IDLE: begin
          if (dbus.dreq.valid) begin
            addr_q   <= dbus.dreq.addr;
            strobe_q <= dbus.dreq.strobe;
            wdata_q  <= dbus.dreq.data;
            cnt      <= load_cnt;
            if (load_cnt == '0) begin
              state     <= RESP;
              data_ok_q <= 1'b1;
              err_q     <= !in_range;
              rdata_q   <= in_range ? mem[idx] : '0;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt <= CW'(1)) begin
            cnt       <= '0;
            state     <= RESP;
            data_ok_q <= 1'b1;
            err_q     <= !in_range;
            rdata_q   <= in_range ? mem[idx] : '0;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  // Reset drops state out of RESP immediately, so an abandoned store never writes.
  always_ff @(posedge clk) begin
    if (state == RESP && in_range) begin
      for (int unsigned i = 0; i < 8; i++) begin
        if (strobe_q[i]) begin
          mem[idx][8*i +: 8] <= wdata_q[8*i +: 8];
        end
      end
    end
  end

  assign dbus.dresp.addr_ok = reset_n && accept;
  assign dbus.dresp.data_ok = data_ok_q;
  assign dbus.dresp.data    = rdata_q;
  assign busy               = (state != IDLE);
  assign err                = err_q;

  // size and the byte offset within a word do not affect indexing
  logic unused;
  assign unused = ^{dbus.dreq.size, off[2:0]};

endmodule

// File: tb/tb_dbus_sram_responder.sv
// Directed, table-driven bench for dbus_sram_responder with three instances
// (LATENCY 1, 3, 4) sharing one clock and reset; a selector steers requests.

module tb_dbus_sram_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic      reset_n;
  dbus_req_t req;
  int        sel;

  int checks   = 0;
  int failures = 0;

  int lat_of [3] = '{1, 3, 4};

  dbus_sram_responder_if bus1 ();
  dbus_sram_responder_if bus3 ();
  dbus_sram_responder_if bus4 ();

  dbus_resp_t resp   [3];
  logic       busy_v [3];
  logic       err_v  [3];

  function automatic dbus_req_t mk(input dbus_req_t r, input int s, input int k);
    dbus_req_t o;
    o       = r;
    o.valid = r.valid && (s == k || s == 3);
    return o;
  endfunction

  assign bus1.dreq = mk(req, sel, 0);
  assign bus3.dreq = mk(req, sel, 1);
  assign bus4.dreq = mk(req, sel, 2);
  assign resp[0]   = bus1.dresp;
  assign resp[1]   = bus3.dresp;
  assign resp[2]   = bus4.dresp;

  dbus_sram_responder #(.LATENCY(1)) u_l1 (
    .clk(clk), .reset_n(reset_n), .dbus(bus1.slave), .busy(busy_v[0]), .err(err_v[0]));
  dbus_sram_responder #(.LATENCY(3)) u_l3 (
    .clk(clk), .reset_n(reset_n), .dbus(bus3.slave), .busy(busy_v[1]), .err(err_v[1]));
  dbus_sram_responder #(.LATENCY(4)) u_l4 (
    .clk(clk), .reset_n(reset_n), .dbus(bus4.slave), .busy(busy_v[2]), .err(err_v[2]));

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One request on instance k; checks acceptance, latency, response, busy.
  task automatic txn(input int k, input logic [63:0] a, input logic [7:0] s,
                     input logic [63:0] d, input logic chk_data,
                     input logic [63:0] exp_d, input logic exp_e, input string tag);
    bit seen;
    bit busy_ok;
    @(negedge clk);
    req = '{valid: 1'b1, addr: a, size: 3'd3, strobe: s, data: d};
    sel = k;
    #1 check({tag, ".addr_ok"}, 64'(resp[k].addr_ok), 64'd1);
    @(posedge clk);
    #1 req.valid = 1'b0;
    seen    = 1'b0;
    busy_ok = 1'b1;
    for (int i = 1; i <= 12 && !seen; i++) begin
      @(negedge clk);
      if (resp[k].data_ok) begin
        seen = 1'b1;
        check({tag, ".lat"}, 64'(i), 64'(lat_of[k]));
        if (chk_data) check({tag, ".data"}, resp[k].data, exp_d);
        check({tag, ".err"}, 64'(err_v[k]), 64'(exp_e));
        check({tag, ".busy_resp"}, 64'(busy_v[k]), 64'd1);
      end else if (!busy_v[k]) begin
        busy_ok = 1'b0;
      end
    end
    check({tag, ".data_ok_seen"}, 64'(seen), 64'd1);
    check({tag, ".busy_wait"}, 64'(busy_ok), 64'd1);
    @(negedge clk);
    check({tag, ".idle_data_ok"}, 64'(resp[k].data_ok), 64'd0);
    check({tag, ".idle_data"}, resp[k].data, 64'd0);
    check({tag, ".idle_busy"}, 64'(busy_v[k]), 64'd0);
  endtask

  typedef struct {
    int          k;
    logic [63:0] addr;
    logic [7:0]  strobe;
    logic [63:0] wdata;
    logic        chk;
    logic [63:0] exp_data;
    logic        exp_err;
  } vec_t;

  localparam int NV = 17;
  vec_t tbl [NV];

  initial begin
    int cnt;
    tbl[0]  = '{0, 64'h8000_0010, 8'hFF, 64'h1122334455667788, 1'b0, 64'h0, 1'b0};
    tbl[1]  = '{0, 64'h8000_0010, 8'h00, 64'h0, 1'b1, 64'h1122334455667788, 1'b0};
    tbl[2]  = '{0, 64'h8000_0010, 8'h0F, 64'hAAAAAAAA_BBBBBBBB, 1'b1, 64'h1122334455667788, 1'b0};
    tbl[3]  = '{0, 64'h8000_0010, 8'h00, 64'h0, 1'b1, 64'h11223344_BBBBBBBB, 1'b0};
    tbl[4]  = '{0, 64'h8000_0017, 8'h00, 64'h0, 1'b1, 64'h11223344_BBBBBBBB, 1'b0};
    tbl[5]  = '{0, 64'h8000_1FF8, 8'hFF, 64'hDEADBEEF_CAFEF00D, 1'b0, 64'h0, 1'b0};
    tbl[6]  = '{0, 64'h8000_1FF8, 8'h00, 64'h0, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0};
    tbl[7]  = '{0, 64'h8000_0000, 8'hFF, 64'h0000_1111_2222_3333, 1'b0, 64'h0, 1'b0};
    tbl[8]  = '{0, 64'h8000_2000, 8'h00, 64'h0, 1'b1, 64'h0, 1'b1};
    tbl[9]  = '{0, 64'h8000_2000, 8'hFF, 64'h5A5A5A5A_5A5A5A5A, 1'b1, 64'h0, 1'b1};
    tbl[10] = '{0, 64'h7FFF_FFF8, 8'hFF, 64'h6666666666666666, 1'b1, 64'h0, 1'b1};
    tbl[11] = '{0, 64'h8000_1FF8, 8'h00, 64'h0, 1'b1, 64'hDEADBEEF_CAFEF00D, 1'b0};
    tbl[12] = '{0, 64'h8000_0000, 8'h00, 64'h0, 1'b1, 64'h0000_1111_2222_3333, 1'b0};
    tbl[13] = '{0, 64'h8000_0010, 8'h81, 64'hEE000000_000000CC, 1'b1, 64'h11223344_BBBBBBBB, 1'b0};
    tbl[14] = '{0, 64'h8000_0010, 8'h00, 64'h0, 1'b1, 64'hEE223344_BBBBBBCC, 1'b0};
    tbl[15] = '{1, 64'h8000_0040, 8'hFF, 64'h0F0F0F0F_F0F0F0F0, 1'b0, 64'h0, 1'b0};
    tbl[16] = '{1, 64'h8000_0040, 8'h00, 64'h0, 1'b1, 64'h0F0F0F0F_F0F0F0F0, 1'b0};

    // Reset held with valid high on every instance: all outputs quiet.
    req     = '0;
    req.valid = 1'b1;
    sel     = 3;
    reset_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      for (int k = 0; k < 3; k++) begin
        check("reset.addr_ok", 64'(resp[k].addr_ok), 64'd0);
        check("reset.data_ok", 64'(resp[k].data_ok), 64'd0);
        check("reset.data", resp[k].data, 64'd0);
        check("reset.busy", 64'(busy_v[k]), 64'd0);
        check("reset.err", 64'(err_v[k]), 64'd0);
      end
    end
    req.valid = 1'b0;
    #1 reset_n = 1'b1;

    for (int v = 0; v < NV; v++) begin
      txn(tbl[v].k, tbl[v].addr, tbl[v].strobe, tbl[v].wdata, tbl[v].chk,
          tbl[v].exp_data, tbl[v].exp_err, $sformatf("vec%0d", v));
    end

    // Valid held continuously at LATENCY=1: one accept every 2 cycles,
    // including the IDLE cycle right after each RESP.
    @(negedge clk);
    req = '{valid: 1'b1, addr: 64'h8000_0010, size: 3'd3, strobe: 8'h00, data: 64'h0};
    sel = 0;
    cnt = 0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (resp[0].data_ok) begin
        cnt++;
        check("b2b.data", resp[0].data, 64'hEE223344_BBBBBBCC);
      end
      if (i == 2) check("b2b.addr_ok_after_resp", 64'(resp[0].addr_ok), 64'd1);
    end
    req.valid = 1'b0;
    check("b2b.pulses", 64'(cnt), 64'd4);
    @(negedge clk);

    // Reset mid-WAIT at LATENCY=4: store abandoned, prior contents survive.
    txn(2, 64'h8000_0010, 8'hFF, 64'h01234567_89ABCDEF, 1'b0, 64'h0, 1'b0, "l4_prime");
    @(negedge clk);
    req = '{valid: 1'b1, addr: 64'h8000_0010, size: 3'd3, strobe: 8'hFF,
            data: 64'hFFFFFFFF_FFFFFFFF};
    sel = 2;
    @(posedge clk);
    #1 req.valid = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 check("midrst.busy_async", 64'(busy_v[2]), 64'd0);
    check("midrst.data_ok_async", 64'(resp[2].data_ok), 64'd0);
    @(negedge clk);
    reset_n = 1'b1;
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (resp[2].data_ok) cnt++;
    end
    check("midrst.no_data_ok", 64'(cnt), 64'd0);
    txn(2, 64'h8000_0010, 8'h00, 64'h0, 1'b1, 64'h01234567_89ABCDEF, 1'b0, "midrst.reload");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
